// File: rtl/two_power_mod_multistep.sv
// Computes 2^P mod M by repeated doubling with conditional subtract, STEPS doublings per cycle.
// Produces the Montgomery pre-scale constant for the RSA datapath; M==0 is reported via o_err.
module two_power_mod_multistep #(
    parameter int WIDTH     = 256,
    parameter int PWR_WIDTH = 32,
    parameter int STEPS     = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [PWR_WIDTH-1:0] i_power,
    input  logic [WIDTH-1:0]     i_modulus,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [WIDTH-1:0]     o_result,
    output logic                 o_err
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [PWR_WIDTH-1:0] STEPS_W = PWR_WIDTH'(STEPS);

    state_t               state_q, state_d, accept_state;
    logic [PWR_WIDTH-1:0] pwr_q, pwr_d, cnt_q, cnt_d;
    logic [WIDTH-1:0]     mod_q, mod_d, r_q, r_d, r_run;
    logic                 err_q, err_d;
    logic                 accept, last_chunk;
    logic [PWR_WIDTH-1:0] rem, step;

    // One doubling; r < m keeps 2r within WIDTH+1 bits, and equality must reduce.
    function automatic logic [WIDTH-1:0] dbl_mod(input logic [WIDTH-1:0] r,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] shifted;
        shifted = {r, 1'b0};
        if (shifted >= {1'b0, m})
            shifted = shifted - {1'b0, m};
        return WIDTH'(shifted);
    endfunction

    assign accept       = i_valid && i_ready;
    assign rem          = pwr_q - cnt_q;
    assign last_chunk   = (rem <= STEPS_W);
    assign step         = (rem < STEPS_W) ? rem : STEPS_W;
    assign accept_state = (i_modulus == '0 || i_power == '0) ? DONE : RUN;

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = accept_state;
            RUN:  if (last_chunk) state_d = DONE;
            DONE: begin
                if (accept)
                    state_d = accept_state;
                else if (o_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        i_ready  = (state_q == IDLE) || (state_q == DONE && o_ready);
        o_valid  = (state_q == DONE);
        o_err    = (state_q == DONE) && err_q;
        o_result = (state_q == DONE && !err_q) ? r_q : '0;
    end

    // Unrolled doublings; stages beyond the remaining count pass r through.
    always_comb begin
        r_run = r_q;
        for (int i = 0; i < STEPS; i++) begin
            if (PWR_WIDTH'(i) < rem)
                r_run = dbl_mod(r_run, mod_q);
        end
    end

    always_comb begin
        pwr_d = pwr_q;
        mod_d = mod_q;
        cnt_d = cnt_q;
        r_d   = r_q;
        err_d = err_q;
        if (accept) begin
            pwr_d = i_power;
            mod_d = i_modulus;
            cnt_d = '0;
            err_d = (i_modulus == '0);
            r_d   = (i_modulus <= WIDTH'(1)) ? '0 : WIDTH'(1);
        end else if (state_q == RUN) begin
            r_d   = r_run;
            cnt_d = cnt_q + step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pwr_q <= '0;
            mod_q <= '0;
            cnt_q <= '0;
            r_q   <= '0;
            err_q <= 1'b0;
        end else begin
            pwr_q <= pwr_d;
            mod_q <= mod_d;
            cnt_q <= cnt_d;
            r_q   <= r_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_two_power_mod_multistep.sv
// Directed bench for two_power_mod_multistep: a STEPS=4 instance and a STEPS=1 instance,
// both WIDTH=16, with hand-computed results and latencies.
module tb_two_power_mod_multistep;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pwr;
    logic [15:0] modulus;
    logic        iv4, ir4, ov4, ordy4, err4;
    logic        iv1, ir1, ov1, ordy1, err1;
    logic [15:0] res4, res1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    two_power_mod_multistep #(.WIDTH(16), .PWR_WIDTH(32), .STEPS(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(iv4), .i_ready(ir4), .i_power(pwr),
        .i_modulus(modulus), .o_valid(ov4), .o_ready(ordy4), .o_result(res4), .o_err(err4));

    two_power_mod_multistep #(.WIDTH(16), .PWR_WIDTH(32), .STEPS(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(iv1), .i_ready(ir1), .i_power(pwr),
        .i_modulus(modulus), .o_valid(ov1), .o_ready(ordy1), .o_result(res1), .o_err(err1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one job on the selected instance (0: STEPS=4, 1: STEPS=1), wait for the
    // result, report value/error/latency in edges after the accept edge, then consume it.
    task automatic run_job(input bit sel, input logic [31:0] p, input logic [15:0] m,
                           output logic [15:0] res, output logic err, output int lat);
        @(negedge clk);
        pwr = p; modulus = m;
        iv4 = !sel; iv1 = sel;
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0; iv1 = 1'b0;
        lat = 0;
        while (!(sel ? ov1 : ov4) && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) chk("timeout", 32'(lat), 32'd0);
        res = sel ? res1 : res4;
        err = sel ? err1 : err4;
        ordy4 = !sel; ordy1 = sel;
        @(negedge clk);
        ordy4 = 1'b0; ordy1 = 1'b0;
    endtask

    initial begin
        logic [15:0] r;
        logic        e;
        int          lat;

        rst = 1'b1; iv4 = 1'b0; iv1 = 1'b0; ordy4 = 1'b0; ordy1 = 1'b0;
        pwr = '0; modulus = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o_valid", 32'(ov4), 32'd0);
        chk("rst_o_result", 32'(res4), 32'd0);
        chk("rst_o_err", 32'(err4), 32'd0);
        chk("rst_i_ready", 32'(ir4), 32'd1);
        rst = 1'b0;

        run_job(1'b0, 32'd0, 16'd13, r, e, lat);
        chk("p0_res", 32'(r), 32'd1);
        chk("p0_err", 32'(e), 32'd0);
        chk("p0_lat", 32'(lat), 32'd0);

        run_job(1'b0, 32'd10, 16'd1000, r, e, lat);
        chk("p10_res", 32'(r), 32'd24);
        chk("p10_lat", 32'(lat), 32'd3);

        run_job(1'b1, 32'd10, 16'd1000, r, e, lat);
        chk("p10s1_res", 32'(r), 32'd24);
        chk("p10s1_lat", 32'(lat), 32'd10);

        run_job(1'b0, 32'd5, 16'd32, r, e, lat);
        chk("ge_bound_res", 32'(r), 32'd0);
        chk("ge_bound_lat", 32'(lat), 32'd2);

        run_job(1'b0, 32'd16, 16'd65535, r, e, lat);
        chk("m65535_res", 32'(r), 32'd1);
        chk("m65535_lat", 32'(lat), 32'd4);

        run_job(1'b0, 32'd7, 16'd1, r, e, lat);
        chk("m1_res", 32'(r), 32'd0);
        chk("m1_err", 32'(e), 32'd0);

        run_job(1'b0, 32'd9, 16'd0, r, e, lat);
        chk("m0_err", 32'(e), 32'd1);
        chk("m0_res", 32'(r), 32'd0);
        chk("m0_lat", 32'(lat), 32'd0);

        // Back-pressure: inputs change while busy, result held, then zero-bubble accept.
        @(negedge clk);
        pwr = 32'd10; modulus = 16'd1000; iv4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        pwr = 32'd3; modulus = 16'd5;
        chk("busy_i_ready", 32'(ir4), 32'd0);
        lat = 0;
        while (!ov4 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        chk("hold_lat", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            chk("hold_o_valid", 32'(ov4), 32'd1);
            chk("hold_o_result", 32'(res4), 32'd24);
            chk("hold_i_ready", 32'(ir4), 32'd0);
            @(negedge clk);
        end
        ordy4 = 1'b1;
        #1;
        chk("same_edge_i_ready", 32'(ir4), 32'd1);
        @(posedge clk);
        @(negedge clk);
        ordy4 = 1'b0; iv4 = 1'b0;
        chk("after_accept_o_valid", 32'(ov4), 32'd0);
        @(negedge clk);
        chk("next_o_valid", 32'(ov4), 32'd1);
        chk("next_o_result", 32'(res4), 32'd3);
        ordy4 = 1'b1;
        @(negedge clk);
        ordy4 = 1'b0;

        // Reset in the middle of a long run aborts the job.
        pwr = 32'd40; modulus = 16'd977; iv4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        iv4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_o_valid", 32'(ov4), 32'd0);
        chk("midrst_i_ready", 32'(ir4), 32'd1);
        chk("midrst_o_result", 32'(res4), 32'd0);
        repeat (12) @(negedge clk);
        chk("aborted_no_result", 32'(ov4), 32'd0);

        run_job(1'b0, 32'd40, 16'd977, r, e, lat);
        chk("p40_res", 32'(r), 32'd543);
        chk("p40_lat", 32'(lat), 32'd10);

        run_job(1'b1, 32'd3, 16'd5, r, e, lat);
        chk("p3s1_res", 32'(r), 32'd3);
        chk("p3s1_lat", 32'(lat), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
